// File: rtl/mist_spi_pkg.sv
// Shared types and constants for the MiST IO-controller SPI host.
package mist_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [1:0] SEL_CONF = 2'd0;
  localparam logic [1:0] SEL_SS2  = 2'd1;
  localparam logic [1:0] SEL_SS3  = 2'd2;
  localparam logic [1:0] SEL_SS4  = 2'd3;

  localparam int CLKDIV_W = 8;

endpackage

// File: rtl/mist_spi_clkgen.sv
// Half-period timer for the SPI host: a down-counter that ticks every CLKDIV
// cycles while running, and toggles SCK on ticks while shifting.
module mist_spi_clkgen
  import mist_spi_pkg::*;
#(
  parameter int unsigned CLKDIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_toggle,
  output logic o_tick,
  output logic o_rise,
  output logic o_fall,
  output logic o_sck
);

  localparam logic [CLKDIV_W-1:0] RELOAD = CLKDIV_W'(CLKDIV - 1);

  logic [CLKDIV_W-1:0] r_cnt;
  logic                r_sck;

  // Counter reloads whenever idle so every phase starts a full period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= RELOAD;
      r_sck <= 1'b0;
    end else begin
      if (!i_run || r_cnt == '0) r_cnt <= RELOAD;
      else                       r_cnt <= r_cnt - 1'b1;
      if (!i_toggle)   r_sck <= 1'b0;
      else if (o_tick) r_sck <= ~r_sck;
    end
  end

  assign o_tick = i_run && (r_cnt == '0);
  assign o_rise = o_tick && i_toggle && !r_sck;
  assign o_fall = o_tick && i_toggle && r_sck;
  assign o_sck  = r_sck;

endmodule

// File: rtl/mist_spi_host.sv
// SPI mode-0 master driving a MiST guest's IO-controller port, byte at a time.
// Define MIST_SPI_HOST_LATE_SAMPLE_EN to sample MISO on falling SCK edges.
//
// state  | meaning
// IDLE   | ready for a byte; a frame may be left open
// SHIFT  | 16 SCK half-phases, then one cycle to publish rx_data
// HOLD   | SCK low for CLKDIV cycles before releasing the select
// GAP    | all selects high for CLKDIV cycles
module mist_spi_host
  import mist_spi_pkg::*;
#(
  parameter int unsigned CLKDIV = 2
) (
  input  logic       CLOCK_27,
  input  logic       RESET_N,
  input  logic       req,
  output logic       ready,
  input  logic [1:0] sel,
  input  logic       last,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       cs_active,
  output logic       SPI_SCK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO,
  output logic       SPI_SS2,
  output logic       SPI_SS3,
  output logic       SPI_SS4,
  output logic       CONF_DATA0
);

  state_t     r_state, w_next;
  logic       r_live;
  logic [7:0] r_tx, r_rx;
  logic [1:0] r_sel;
  logic       r_last, r_open, r_fin;
  logic [2:0] r_nfall;
  logic       w_run, w_toggle, w_tick, w_rise, w_fall, w_sample, w_clash, w_accept;

  mist_spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
    .i_clk    (CLOCK_27),
    .i_rst_n  (RESET_N),
    .i_run    (w_run),
    .i_toggle (w_toggle),
    .o_tick   (w_tick),
    .o_rise   (w_rise),
    .o_fall   (w_fall),
    .o_sck    (SPI_SCK)
  );

`ifdef MIST_SPI_HOST_LATE_SAMPLE_EN
  assign w_sample = w_fall;
`else
  assign w_sample = w_rise;
`endif

  // A request for another select must wait until the open frame is closed.
  assign w_clash  = r_open && (sel != r_sel);
  assign w_accept = req && ready;

  always_ff @(posedge CLOCK_27 or negedge RESET_N) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (r_live && req) w_next = w_clash ? ST_HOLD : ST_SHIFT;
      ST_SHIFT: if (r_fin)         w_next = r_last ? ST_HOLD : ST_IDLE;
      ST_HOLD:  if (w_tick)        w_next = ST_GAP;
      ST_GAP:   if (w_tick)        w_next = ST_IDLE;
      default:                     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    w_run    = 1'b0;
    w_toggle = 1'b0;
    SPI_MOSI = 1'b0;
    unique case (r_state)
      ST_IDLE:  ready = r_live && !w_clash;
      ST_SHIFT: begin
        w_run    = !r_fin;
        w_toggle = !r_fin;
        SPI_MOSI = r_tx[7];
      end
      ST_HOLD, ST_GAP: w_run = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_27 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_live   <= 1'b0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_sel    <= SEL_CONF;
      r_last   <= 1'b0;
      r_open   <= 1'b0;
      r_fin    <= 1'b0;
      r_nfall  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      r_live   <= 1'b1;
      rx_valid <= 1'b0;
      if (w_accept) begin
        r_tx    <= tx_data;
        r_sel   <= sel;
        r_last  <= last;
        r_open  <= 1'b1;
        r_fin   <= 1'b0;
        r_nfall <= '0;
      end
      if (r_state == ST_SHIFT) begin
        if (w_sample) r_rx <= {r_rx[6:0], SPI_MISO};
        if (w_fall) begin
          r_tx    <= {r_tx[6:0], 1'b0};
          r_nfall <= r_nfall + 3'd1;
          if (r_nfall == 3'd7) r_fin <= 1'b1;
        end
        if (r_fin) begin
          rx_valid <= 1'b1;
          rx_data  <= r_rx;
          r_fin    <= 1'b0;
        end
      end
      if (r_state == ST_HOLD && w_tick) r_open <= 1'b0;
    end
  end

  assign cs_active  = r_open;
  assign CONF_DATA0 = !(r_open && r_sel == SEL_CONF);
  assign SPI_SS2    = !(r_open && r_sel == SEL_SS2);
  assign SPI_SS3    = !(r_open && r_sel == SEL_SS3);
  assign SPI_SS4    = !(r_open && r_sel == SEL_SS4);

endmodule

// File: tb/tb_mist_spi_host.sv
// Directed bench for mist_spi_host: instance A at CLKDIV=2 with a shifting slave,
// instance B at CLKDIV=1 with a MOSI->MISO loopback (direct or one cycle late).
module tb_mist_spi_host;

  int checks   = 0;
  int failures = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a_req = 1'b0, a_last = 1'b0;
  logic [1:0] a_sel = 2'd0;
  logic [7:0] a_tx = 8'h00, a_slave_byte = 8'h00;
  logic       a_ready, a_rxv, a_cs, a_sck, a_mosi, a_miso, a_ss2, a_ss3, a_ss4, a_conf;
  logic [7:0] a_rxd;

  logic       b_req = 1'b0, b_last = 1'b0, b_dly = 1'b0;
  logic [1:0] b_sel = 2'd0;
  logic [7:0] b_tx = 8'h00;
  logic       b_ready, b_rxv, b_cs, b_sck, b_mosi, b_miso, b_ss2, b_ss3, b_ss4, b_conf;
  logic [7:0] b_rxd;

  mist_spi_host #(.CLKDIV(2)) u_dut (
    .CLOCK_27(clk), .RESET_N(rst_n), .req(a_req), .ready(a_ready), .sel(a_sel),
    .last(a_last), .tx_data(a_tx), .rx_data(a_rxd), .rx_valid(a_rxv),
    .cs_active(a_cs), .SPI_SCK(a_sck), .SPI_MOSI(a_mosi), .SPI_MISO(a_miso),
    .SPI_SS2(a_ss2), .SPI_SS3(a_ss3), .SPI_SS4(a_ss4), .CONF_DATA0(a_conf)
  );

  mist_spi_host #(.CLKDIV(1)) u_dut1 (
    .CLOCK_27(clk), .RESET_N(rst_n), .req(b_req), .ready(b_ready), .sel(b_sel),
    .last(b_last), .tx_data(b_tx), .rx_data(b_rxd), .rx_valid(b_rxv),
    .cs_active(b_cs), .SPI_SCK(b_sck), .SPI_MOSI(b_mosi), .SPI_MISO(b_miso),
    .SPI_SS2(b_ss2), .SPI_SS3(b_ss3), .SPI_SS4(b_ss4), .CONF_DATA0(b_conf)
  );

  // Slave A: loads a byte on acceptance, shifts MISO after each falling SCK,
  // captures MOSI on rising SCK.
  logic [7:0] a_slave, a_srx;
  logic       a_sck_d;
  always @(posedge clk) begin
    a_sck_d <= a_sck;
    if (a_req && a_ready)        a_slave <= a_slave_byte;
    else if (a_sck_d && !a_sck)  a_slave <= {a_slave[6:0], 1'b0};
    if (!a_sck_d && a_sck)       a_srx <= {a_srx[6:0], a_mosi};
  end
  assign a_miso = a_slave[7];

  logic b_mosi_q;
  always @(posedge clk) b_mosi_q <= b_mosi;
  assign b_miso = b_dly ? b_mosi_q : b_mosi;

  int         a_rxv_cnt = 0, a_both_low = 0, a_ss2_rises = 0, a_sck_rises = 0;
  int         a_ss2_rise_cyc = 0, a_ss4_fall_cyc = 0;
  int         a_rx_cyc [0:15];
  logic [7:0] a_rx_log [0:15];
  logic [7:0] a_srx_log[0:15];
  logic       a_ss2_q = 1'b1, a_ss4_q = 1'b1, a_sck_q = 1'b0;

  always @(negedge clk) begin
    a_sck_q <= a_sck;
    a_ss2_q <= a_ss2;
    a_ss4_q <= a_ss4;
    if (a_rxv) begin
      a_rx_log[a_rxv_cnt % 16]  <= a_rxd;
      a_srx_log[a_rxv_cnt % 16] <= a_srx;
      a_rx_cyc[a_rxv_cnt % 16]  <= cyc;
      a_rxv_cnt <= a_rxv_cnt + 1;
    end
    if ($countones({a_ss2, a_ss3, a_ss4, a_conf}) < 3) a_both_low <= a_both_low + 1;
    if (a_ss2 && !a_ss2_q) begin
      a_ss2_rises    <= a_ss2_rises + 1;
      a_ss2_rise_cyc <= cyc;
    end
    if (!a_ss4 && a_ss4_q) a_ss4_fall_cyc <= cyc;
    if (a_sck && !a_sck_q) a_sck_rises <= a_sck_rises + 1;
  end

  task automatic send_a(input logic [1:0] s, input logic l, input logic [7:0] d,
                        input logic [7:0] sb, output int acc);
    int n = 0;
    @(negedge clk);
    a_sel = s; a_last = l; a_tx = d; a_slave_byte = sb; a_req = 1'b1;
    #1;
    while (!a_ready && n < 400) begin @(negedge clk); #1; n++; end
    if (!a_ready) begin
      checks++; failures++;
      $display("FAIL send_a_timeout ready=%b required=1", a_ready);
    end
    acc = cyc;
    @(posedge clk); #1;
    a_req = 1'b0;
  endtask

  task automatic wait_rx_a(input int target);
    int n = 0;
    while (a_rxv_cnt < target && n < 400) begin @(negedge clk); #1; n++; end
    if (a_rxv_cnt < target) begin
      checks++; failures++;
      $display("FAIL wait_rx_timeout count=%0d required=%0d", a_rxv_cnt, target);
    end
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (!(a_ready && !a_cs) && n < 400) begin @(negedge clk); #1; n++; end
    if (!(a_ready && !a_cs)) begin
      checks++; failures++;
      $display("FAIL wait_idle_timeout ready=%b cs=%b required=1,0", a_ready, a_cs);
    end
  endtask

  task automatic xfer_b(input logic [7:0] d, output logic [7:0] got,
                        output int t_rx, output int t_rdy);
    int n = 0;
    int acc;
    got = 8'h00; t_rx = -1; t_rdy = -1;
    @(negedge clk);
    b_sel = 2'd0; b_last = 1'b1; b_tx = d; b_req = 1'b1;
    #1;
    while (!b_ready && n < 400) begin @(negedge clk); #1; n++; end
    acc = cyc;
    @(posedge clk); #1;
    b_req = 1'b0;
    n = 0;
    while (!b_rxv && n < 400) begin @(negedge clk); #1; n++; end
    if (b_rxv) begin t_rx = cyc - acc; got = b_rxd; end
    n = 0;
    while (!b_ready && n < 400) begin @(negedge clk); #1; n++; end
    if (b_ready) t_rdy = cyc - acc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", a_ready); end
    checks++; if (a_rxv !== 1'b0) begin failures++; $display("FAIL rst_rx_valid got=%b exp=0", a_rxv); end
    checks++; if (a_rxd !== 8'h00) begin failures++; $display("FAIL rst_rx_data got=%h exp=00", a_rxd); end
    checks++; if ({a_cs, a_sck, a_mosi} !== 3'b000) begin failures++; $display("FAIL rst_cs_sck_mosi got=%b exp=000", {a_cs, a_sck, a_mosi}); end
    checks++; if ({a_ss2, a_ss3, a_ss4, a_conf} !== 4'hF) begin failures++; $display("FAIL rst_selects got=%b exp=1111", {a_ss2, a_ss3, a_ss4, a_conf}); end
    checks++; if ({b_ready, b_cs, b_sck, b_mosi, b_ss2, b_ss3, b_ss4, b_conf} !== 8'b00001111) begin failures++; $display("FAIL rst_b_outputs got=%b exp=00001111", {b_ready, b_cs, b_sck, b_mosi, b_ss2, b_ss3, b_ss4, b_conf}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b11) begin failures++; $display("FAIL rst_release_ready got=%b exp=11", {a_ready, b_ready}); end
  endtask

  task automatic test_single_byte();
    logic       r_conf[0:40], r_sck[0:40], r_mosi[0:40], r_rdy[0:40], r_rxv[0:40], r_cs[0:40];
    logic [7:0] r_rxd[0:40];
    logic [7:0] exp_tx;
    int acc, bad;
    exp_tx = 8'hA5;
    send_a(2'd0, 1'b1, 8'hA5, 8'h3C, acc);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk); #1;
      r_conf[c] = a_conf; r_sck[c] = a_sck; r_mosi[c] = a_mosi;
      r_rdy[c] = a_ready; r_rxv[c] = a_rxv; r_rxd[c] = a_rxd; r_cs[c] = a_cs;
    end
    checks++; if (r_conf[1] !== 1'b0) begin failures++; $display("FAIL single_conf_c1 got=%b exp=0", r_conf[1]); end
    checks++; if (r_conf[35] !== 1'b0) begin failures++; $display("FAIL single_conf_c35 got=%b exp=0", r_conf[35]); end
    checks++; if (r_conf[36] !== 1'b1) begin failures++; $display("FAIL single_conf_c36 got=%b exp=1", r_conf[36]); end
    checks++; if (r_cs[36] !== 1'b0) begin failures++; $display("FAIL single_cs_c36 got=%b exp=0", r_cs[36]); end
    checks++; if ({r_sck[2], r_sck[3]} !== 2'b01) begin failures++; $display("FAIL single_first_rise got=%b exp=01", {r_sck[2], r_sck[3]}); end
    checks++; if ({r_sck[32], r_sck[33]} !== 2'b10) begin failures++; $display("FAIL single_last_fall got=%b exp=10", {r_sck[32], r_sck[33]}); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (r_mosi[3 + 4 * k] !== exp_tx[7 - k]) begin
        failures++; $display("FAIL single_mosi_bit%0d got=%b exp=%b", 7 - k, r_mosi[3 + 4 * k], exp_tx[7 - k]);
      end
    end
    bad = 0;
    for (int c = 1; c <= 40; c++) if (r_rxv[c] !== (c == 34)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL single_rx_valid_timing wrong_cycles=%0d exp=0", bad); end
    checks++; if (r_rxd[34] !== 8'h3C) begin failures++; $display("FAIL single_rx_data got=%h exp=3c", r_rxd[34]); end
    checks++; if ({r_rdy[34], r_rdy[37], r_rdy[38]} !== 3'b001) begin failures++; $display("FAIL single_ready_return got=%b exp=001", {r_rdy[34], r_rdy[37], r_rdy[38]}); end
  endtask

  task automatic test_back_to_back();
    int acc, base, rises0, both0;
    base = a_rxv_cnt; rises0 = a_ss2_rises; both0 = a_both_low;
    send_a(2'd1, 1'b0, 8'h14, 8'h5A, acc);
    send_a(2'd1, 1'b0, 8'h00, 8'hC3, acc);
    send_a(2'd1, 1'b1, 8'hFF, 8'h01, acc);
    checks++; if (a_ss2_rises - rises0 !== 0) begin failures++; $display("FAIL b2b_ss2_held rises=%0d exp=0", a_ss2_rises - rises0); end
    wait_rx_a(base + 3);
    wait_idle_a();
    checks++; if (a_rxv_cnt - base !== 3) begin failures++; $display("FAIL b2b_rx_count got=%0d exp=3", a_rxv_cnt - base); end
    checks++; if (a_ss2_rises - rises0 !== 1) begin failures++; $display("FAIL b2b_ss2_close rises=%0d exp=1", a_ss2_rises - rises0); end
    checks++; if ({a_rx_log[base % 16], a_rx_log[(base + 1) % 16], a_rx_log[(base + 2) % 16]} !== 24'h5AC301) begin
      failures++; $display("FAIL b2b_rx_bytes got=%h %h %h exp=5a c3 01", a_rx_log[base % 16], a_rx_log[(base + 1) % 16], a_rx_log[(base + 2) % 16]);
    end
    checks++; if ({a_srx_log[base % 16], a_srx_log[(base + 1) % 16], a_srx_log[(base + 2) % 16]} !== 24'h1400FF) begin
      failures++; $display("FAIL b2b_mosi_bytes got=%h %h %h exp=14 00 ff", a_srx_log[base % 16], a_srx_log[(base + 1) % 16], a_srx_log[(base + 2) % 16]);
    end
    checks++; if (a_rx_cyc[(base + 1) % 16] - a_rx_cyc[base % 16] !== 34) begin
      failures++; $display("FAIL b2b_byte_period got=%0d exp=34", a_rx_cyc[(base + 1) % 16] - a_rx_cyc[base % 16]);
    end
    checks++; if (a_both_low - both0 !== 0) begin failures++; $display("FAIL b2b_multi_select cycles=%0d exp=0", a_both_low - both0); end
  endtask

  task automatic test_sel_switch();
    int acc, base, both0;
    base = a_rxv_cnt; both0 = a_both_low;
    send_a(2'd1, 1'b0, 8'h11, 8'h22, acc);
    wait_rx_a(base + 1);
    a_sel = 2'd3; a_last = 1'b1; a_tx = 8'h33; a_slave_byte = 8'h44; a_req = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL switch_ready_blocked got=%b exp=0", a_ready); end
    send_a(2'd3, 1'b1, 8'h33, 8'h44, acc);
    wait_rx_a(base + 2);
    wait_idle_a();
    checks++; if (a_ss4_fall_cyc - a_ss2_rise_cyc !== 3) begin failures++; $display("FAIL switch_gap got=%0d exp=3", a_ss4_fall_cyc - a_ss2_rise_cyc); end
    checks++; if (a_both_low - both0 !== 0) begin failures++; $display("FAIL switch_multi_select cycles=%0d exp=0", a_both_low - both0); end
    checks++; if (a_rx_log[(base + 1) % 16] !== 8'h44) begin failures++; $display("FAIL switch_rx_data got=%h exp=44", a_rx_log[(base + 1) % 16]); end
  endtask

  task automatic test_reset_mid();
    int acc, sr0, rx0, n;
    sr0 = a_sck_rises;
    send_a(2'd0, 1'b1, 8'hF0, 8'h0F, acc);
    n = 0;
    while (a_sck_rises - sr0 < 5 && n < 400) begin @(negedge clk); #1; n++; end
    rst_n = 1'b0;
    #1;
    checks++; if ({a_conf, a_ss2, a_ss3, a_ss4} !== 4'hF) begin failures++; $display("FAIL midrst_selects got=%b exp=1111", {a_conf, a_ss2, a_ss3, a_ss4}); end
    checks++; if ({a_sck, a_mosi, a_cs, a_ready, a_rxv} !== 5'b00000) begin failures++; $display("FAIL midrst_outputs got=%b exp=00000", {a_sck, a_mosi, a_cs, a_ready, a_rxv}); end
    checks++; if (a_rxd !== 8'h00) begin failures++; $display("FAIL midrst_rx_data got=%h exp=00", a_rxd); end
    rx0 = a_rxv_cnt;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    checks++; if (a_rxv_cnt - rx0 !== 0) begin failures++; $display("FAIL midrst_no_rx_valid pulses=%0d exp=0", a_rxv_cnt - rx0); end
    send_a(2'd2, 1'b1, 8'h5C, 8'hE7, acc);
    wait_rx_a(rx0 + 1);
    wait_idle_a();
    checks++; if (a_rx_log[rx0 % 16] !== 8'hE7) begin failures++; $display("FAIL midrst_after_rx got=%h exp=e7", a_rx_log[rx0 % 16]); end
    checks++; if (a_srx_log[rx0 % 16] !== 8'h5C) begin failures++; $display("FAIL midrst_after_mosi got=%h exp=5c", a_srx_log[rx0 % 16]); end
  endtask

  task automatic test_clkdiv1();
    logic [7:0] got;
    int t_rx, t_rdy;
    b_dly = 1'b0;
    xfer_b(8'h81, got, t_rx, t_rdy);
    checks++; if (got !== 8'h81) begin failures++; $display("FAIL div1_loop_data got=%h exp=81", got); end
    checks++; if (t_rx !== 18) begin failures++; $display("FAIL div1_rx_cycle got=%0d exp=18", t_rx); end
    checks++; if (t_rdy !== 20) begin failures++; $display("FAIL div1_ready_cycle got=%0d exp=20", t_rdy); end
    xfer_b(8'h3A, got, t_rx, t_rdy);
    checks++; if (got !== 8'h3A) begin failures++; $display("FAIL div1_loop_data2 got=%h exp=3a", got); end
    b_dly = 1'b1;
    xfer_b(8'h81, got, t_rx, t_rdy);
    checks++; if (t_rx !== 18) begin failures++; $display("FAIL div1_late_rx_cycle got=%0d exp=18", t_rx); end
`ifdef MIST_SPI_HOST_LATE_SAMPLE_EN
    checks++; if (got !== 8'h81) begin failures++; $display("FAIL div1_late_data got=%h exp=81", got); end
`endif
    b_dly = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_sel_switch();
    test_reset_mid();
    test_clkdiv1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
